// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state encodings and forwarding-mux select codes shared by the hazard unit.
package hazard_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  typedef enum logic [1:0] {MEM_IDLE, MEM_ADDR, MEM_DATA} mem_state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  function automatic logic [1:0] fwd_code(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_bus_fsm.sv
// hazard_bus_fsm: data-bus req/addr_ok/data_ok handshake for M-stage loads and stores.
module hazard_bus_fsm
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic memen,
  input  logic exc,
  input  logic d_addr_ok,
  input  logic d_data_ok,
  output logic d_req,
  output logic memstall
);
  mem_state_t state, next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MEM_IDLE;
    else      state <= next;
  end
  // An exception only blocks the launch; an accepted request always runs to completion.
  always_comb begin
    next = state;
    unique case (state)
      MEM_IDLE: next = (memen & ~exc) ? MEM_ADDR : MEM_IDLE;
      MEM_ADDR: next = d_addr_ok ? (d_data_ok ? MEM_IDLE : MEM_DATA) : MEM_ADDR;
      MEM_DATA: next = d_data_ok ? MEM_IDLE : MEM_DATA;
      default:  next = MEM_IDLE;
    endcase
  end
  assign d_req    = state == MEM_ADDR;
  assign memstall = (state == MEM_IDLE) ? (memen & ~exc) : ~d_data_ok;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/forward control with divider and data-bus handshakes.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              divE,
  input  logic              div_ready,
  input  logic              memenM,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  input  logic              inst_stall,
  input  logic              excM,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_start,
  output logic              d_req,
  output logic [CNT_W-1:0]  stall_cycles
);
  div_state_t div_state, div_next;
  logic memstall, divstall, lwstall, brstall;
  logic wm_ok, ww_ok, r_exc, r_mem, r_div, r_hz;
  assign wm_ok = regwriteM & (writeregM != '0);
  assign ww_ok = regwriteW & (writeregW != '0);
  assign forwardaE = fwd_code(wm_ok & (writeregM == rsE), ww_ok & (writeregW == rsE));
  assign forwardbE = fwd_code(wm_ok & (writeregM == rtE), ww_ok & (writeregW == rtE));
  assign forwardaD = wm_ok & (writeregM == rsD);
  assign forwardbD = wm_ok & (writeregM == rtD);
  assign lwstall = memtoregE & ((rtE == rsD) | (rtE == rtD));
  assign brstall = (branchD | jrD) &
                   ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                    (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
  hazard_bus_fsm u_bus (
    .clk       (clk),
    .rst       (rst),
    .memen     (memenM),
    .exc       (excM),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_req     (d_req),
    .memstall  (memstall)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_state <= DIV_IDLE;
    else      div_state <= div_next;
  end
  // DONE never stalls, so the div in E retires instead of being relaunched.
  always_comb begin
    div_next = DIV_IDLE;
    unique case (div_state)
      DIV_IDLE: div_next = (divE & ~excM) ? DIV_BUSY : DIV_IDLE;
      DIV_BUSY: div_next = excM ? DIV_IDLE : div_ready ? DIV_DONE : DIV_BUSY;
      default:  div_next = DIV_IDLE;
    endcase
  end
  assign div_start = div_state == DIV_BUSY;
  assign divstall  = ((div_state == DIV_IDLE) & divE & ~excM) |
                     ((div_state == DIV_BUSY) & ~div_ready);
  assign r_exc = excM & ~memstall;
  assign r_mem = memstall;
  assign r_div = ~r_exc & ~r_mem & divstall;
  assign r_hz  = ~r_exc & ~r_mem & ~divstall & (lwstall | brstall | inst_stall);
  assign stallF = r_mem | r_div | r_hz;
  assign stallD = r_mem | r_div | r_hz;
  assign stallE = r_mem | r_div;
  assign stallM = r_mem;
  assign flushD = r_exc;
  assign flushE = r_exc | r_hz;
  assign flushM = r_exc | r_div;
  assign flushW = r_exc | r_mem;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               stall_cycles <= '0;
    else if (stallF && stall_cycles != '1)  stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed literal cases plus randomized run checked against a rule-level model.
module tb_hazard_unit;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jrD;
  logic divE, div_ready, memenM, d_addr_ok, d_data_ok, inst_stall, excM;
  logic forwardaD, forwardbD, stallF, stallD, stallE, stallM;
  logic flushD, flushE, flushM, flushW, div_start, d_req;
  logic [1:0] forwardaE, forwardbE;
  logic [CW-1:0] stall_cycles;
  int tests = 0, fails = 0;
  int mem_ph = 0, div_ph = 0, scnt = 0;

  hazard_unit #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .jrD(jrD),
    .divE(divE), .div_ready(div_ready), .memenM(memenM), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .inst_stall(inst_stall), .excM(excM),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
    .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW), .div_start(div_start), .d_req(d_req), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // mem_ph: 0 no transaction, 1 waiting for accept, 2 waiting for data.
  // div_ph: 0 idle, 1 dividing, 2 result cycle.
  function automatic logic [9:0] model_ctl();
    logic ms, ds, lw, br;
    logic [9:0] v;
    ms = (mem_ph != 0) ? !d_data_ok : (memenM && !excM);
    ds = (div_ph == 0 && divE && !excM) || (div_ph == 1 && !div_ready);
    lw = memtoregE && (rtE == rsD || rtE == rtD);
    br = (branchD || jrD) &&
         ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
          (memtoregM && (writeregM == rsD || writeregM == rtD)));
    if (excM && !ms)                 v = 10'b0000_1111_00;
    else if (ms)                     v = 10'b1111_0001_00;
    else if (ds)                     v = 10'b1110_0010_00;
    else if (lw || br || inst_stall) v = 10'b1100_0100_00;
    else                             v = 10'b0;
    v[1] = div_ph == 1;
    v[0] = mem_ph == 1;
    return v;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] r);
    if (regwriteM && writeregM != 0 && writeregM == r) return 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [9:0] c;
    if (!rst) begin
      mem_ph <= 0; div_ph <= 0; scnt <= 0;
    end else begin
      c = model_ctl();
      if (c[9] && scnt < CMAX) scnt <= scnt + 1;
      case (mem_ph)
        0: mem_ph <= (memenM && !excM) ? 1 : 0;
        1: mem_ph <= d_addr_ok ? (d_data_ok ? 0 : 2) : 1;
        default: mem_ph <= d_data_ok ? 0 : 2;
      endcase
      case (div_ph)
        0: div_ph <= (divE && !excM) ? 1 : 0;
        1: div_ph <= excM ? 0 : (div_ready ? 2 : 1);
        default: div_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_start, d_req}, model_ctl());
    chk("fwdaE", forwardaE, model_fwd(rsE));
    chk("fwdbE", forwardbE, model_fwd(rtE));
    chk("fwdD", {forwardaD, forwardbD}, {model_fwd(rsD) == 2'b10, model_fwd(rtD) == 2'b10});
    chk("stall_cycles", stall_cycles, scnt);
  end

  task automatic zero();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jrD} = '0;
    {divE, div_ready, memenM, d_addr_ok, d_data_ok, inst_stall, excM} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_div [7];
    logic [2:0] exp_mem [5];
    exp_div = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    exp_mem = '{3'b110, 3'b111, 3'b111, 3'b110, 3'b000};
    zero();
    #3;
    chk("reset_all", {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, stallM,
                      flushD, flushE, flushM, flushW, div_start, d_req, stall_cycles}, 0);
    tick(); rst = 1'b1;
    tick(); zero(); memtoregE = 1; regwriteE = 1; writeregE = 2; rtE = 2; rsD = 2; #1;
    chk("lw_stall", {stallF, stallD, flushE, stallE}, 4'b1110);
    tick(); zero(); rsE = 2; regwriteW = 1; writeregW = 2; #1;
    chk("lw_fwdW", {forwardaE, stallF}, 3'b010);
    tick(); zero(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3; #1;
    chk("br_stall", {stallD, flushE}, 2'b11);
    tick(); zero(); branchD = 1; rsD = 3; regwriteM = 1; writeregM = 3; #1;
    chk("br_fwdD", {forwardaD, stallD}, 2'b10);
    tick(); zero(); divE = 1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      div_ready = (c == 5); #1;
      chk($sformatf("div_c%0d", c), {div_start, stallE}, exp_div[c]);
    end
    tick(); zero(); memenM = 1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      d_addr_ok = (c == 2); d_data_ok = (c == 4); #1;
      chk($sformatf("mem_c%0d", c), {stallM, flushW, d_req}, exp_mem[c]);
    end
    tick(); zero(); divE = 1;
    tick(); excM = 1; #1;
    chk("exc_flush", {flushD, flushE, flushM, flushW, div_start}, 5'b11111);
    tick(); zero(); #1;
    chk("exc_idle", {div_start, stallE}, 2'b00);
    tick(); zero(); memenM = 1;
    tick(); d_addr_ok = 1;
    tick(); zero(); #1;
    chk("data_state", {d_req, stallM}, 2'b01);
    #1 rst = 1'b0; #1;
    chk("rst_mid", {d_req, stallF, stallD, stallE, stallM, stall_cycles}, 0);
    tick(); rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
      branchD = ($urandom_range(0, 3) == 0); jrD = ($urandom_range(0, 7) == 0);
      divE = ($urandom_range(0, 7) == 0); div_ready = ($urandom_range(0, 3) == 0);
      memenM = ($urandom_range(0, 5) == 0);
      d_addr_ok = 1'($urandom_range(0, 1)); d_data_ok = 1'($urandom_range(0, 1));
      inst_stall = ($urandom_range(0, 7) == 0); excM = ($urandom_range(0, 15) == 0);
    end
    tick(); zero();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
